// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command sequencer.
// Optional CRC7 generation is controlled by the SD_CMD_CRC7_GEN_EN macro.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SEND,
        ST_POLL,
        ST_DONE
    } sd_state_e;

    typedef enum logic [1:0] {
        HS_ISSUE,
        HS_ARM,
        HS_WAIT
    } sd_hs_e;

    localparam logic [1:0] SD_START_BITS = 2'b01;
    localparam logic       SD_STOP_BIT   = 1'b1;
    localparam logic [7:0] SD_FILL_BYTE  = 8'hFF;
    localparam logic [6:0] SD_CRC7_POLY  = 7'h09;
    localparam int         SD_HS_GUARD   = 4;

    // MSB-first CRC7 update over one byte.
    function automatic logic [6:0] sd_crc7_byte(input logic [6:0] crc, input logic [7:0] b);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ b[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ SD_CRC7_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator used to build the SD command token CRC.
// Only instantiated when SD_CMD_CRC7_GEN_EN is defined.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic [6:0] crc_out
);

    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 7'd0;
        end else if (byte_valid) begin
            crc_d = sd_crc7_byte(crc_q, byte_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= 7'd0;
        else     crc_q <= crc_d;
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD SPI-mode command sequencer: frames a command token, drives the byte engine, polls R1.
// Define SD_CMD_CRC7_GEN_EN to compute the token CRC7 in hardware instead of using cmd_crc.
module sd_cmd_ctrl
    import sd_pkg::*;
#(
    parameter int NCR_MAX   = 8,
    parameter int PRE_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [7:0]  cmd_r1,
    output logic        cmd_timeout,
    output logic [7:0]  spi_wdata,
    output logic        spi_write_en,
    output logic        spi_read_en,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_write_busy,
    input  logic        spi_read_busy,
    output sd_state_e   dbg_state
);

    sd_state_e   state_q, state_d;
    sd_hs_e      hs_q, hs_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [1:0]  guard_q, guard_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  r1_q, r1_d;
    logic        timeout_q, timeout_d;
    logic        active, byte_done;
    logic [7:0]  rx_byte, tx_byte;
    logic [6:0]  token_crc;

`ifdef SD_CMD_CRC7_GEN_EN
    logic crc_clear, crc_valid;
    logic unused_cmd_crc;
    assign unused_cmd_crc = ^cmd_crc;

    sd_crc7 u_crc7 (
        .clk        (clk),
        .rst        (rst),
        .clear      (crc_clear),
        .byte_valid (crc_valid),
        .byte_in    (tx_byte),
        .crc_out    (token_crc)
    );

    always_comb begin
        crc_clear = (state_q == ST_IDLE) && cmd_start;
        crc_valid = (state_q == ST_SEND) && byte_done && (byte_cnt_q != 4'd5);
    end
`else
    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if ((state_q == ST_IDLE) && cmd_start) crc_d = cmd_crc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= 7'd0;
        else     crc_q <= crc_d;
    end

    assign token_crc = crc_q;
`endif

    assign active = (state_q == ST_PRE) || (state_q == ST_SEND) || (state_q == ST_POLL);

    always_comb begin
        tx_byte = SD_FILL_BYTE;
        if (state_q == ST_SEND) begin
            case (byte_cnt_q)
                4'd0:    tx_byte = {SD_START_BITS, idx_q};
                4'd1:    tx_byte = arg_q[31:24];
                4'd2:    tx_byte = arg_q[23:16];
                4'd3:    tx_byte = arg_q[15:8];
                4'd4:    tx_byte = arg_q[7:0];
                default: tx_byte = {token_crc, SD_STOP_BIT};
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        hs_d       = hs_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        guard_d    = guard_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        r1_d       = r1_q;
        timeout_d  = timeout_q;
        byte_done  = 1'b0;
        rx_byte    = SD_FILL_BYTE;

        // Byte handshake; a stalled engine completes the byte as 0xFF after the guard.
        if (active) begin
            case (hs_q)
                HS_ISSUE: begin
                    hs_d    = HS_ARM;
                    guard_d = 2'd0;
                end
                HS_ARM: begin
                    if (spi_write_busy || spi_read_busy) begin
                        hs_d = HS_WAIT;
                    end else if (guard_q == 2'(SD_HS_GUARD - 1)) begin
                        byte_done = 1'b1;
                    end else begin
                        guard_d = guard_q + 2'd1;
                    end
                end
                HS_WAIT: begin
                    if (!spi_write_busy && !spi_read_busy) begin
                        byte_done = 1'b1;
                        rx_byte   = spi_rdata;
                    end
                end
                default: hs_d = HS_ISSUE;
            endcase
            if (byte_done) hs_d = HS_ISSUE;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    idx_d      = cmd_index;
                    arg_d      = cmd_arg;
                    r1_d       = SD_FILL_BYTE;
                    timeout_d  = 1'b0;
                    byte_cnt_d = 4'd0;
                    hs_d       = HS_ISSUE;
                    state_d    = (PRE_BYTES == 0) ? ST_SEND : ST_PRE;
                end
            end
            ST_PRE: begin
                if (byte_done) begin
                    if (byte_cnt_q == 4'(PRE_BYTES - 1)) begin
                        byte_cnt_d = 4'd0;
                        state_d    = ST_SEND;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            ST_SEND: begin
                if (byte_done) begin
                    if (byte_cnt_q == 4'd5) begin
                        poll_cnt_d = 8'd0;
                        state_d    = ST_POLL;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            ST_POLL: begin
                if (byte_done) begin
                    if (!rx_byte[7]) begin
                        r1_d    = rx_byte;
                        state_d = ST_DONE;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                        if (poll_cnt_q + 8'd1 == 8'(NCR_MAX)) begin
                            r1_d      = SD_FILL_BYTE;
                            timeout_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hs_q       <= HS_ISSUE;
            byte_cnt_q <= 4'd0;
            poll_cnt_q <= 8'd0;
            guard_q    <= 2'd0;
            idx_q      <= 6'd0;
            arg_q      <= 32'd0;
            r1_q       <= SD_FILL_BYTE;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hs_q       <= hs_d;
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            guard_q    <= guard_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            r1_q       <= r1_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cmd_busy     = active;
    assign cmd_done     = (state_q == ST_DONE);
    assign cmd_r1       = r1_q;
    assign cmd_timeout  = timeout_q;
    assign spi_wdata    = tx_byte;
    assign spi_write_en = active && (hs_q == HS_ISSUE);
    assign spi_read_en  = active && (hs_q == HS_ISSUE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: table of commands plus hand-written reset/restart/stall sequences.
// Expected token bytes use correct CRCs so the same tables hold with or without SD_CMD_CRC7_GEN_EN.
module tb_sd_cmd_ctrl;
    import sd_pkg::*;

    localparam int NCR = 8;
    localparam int PRE = 1;

    logic        clk;
    logic        rst;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        cmd_busy, cmd_done, cmd_timeout;
    logic [7:0]  cmd_r1;
    logic [7:0]  spi_wdata;
    logic        spi_write_en, spi_read_en;
    logic [7:0]  spi_rdata;
    logic        spi_write_busy, spi_read_busy;
    sd_state_e   dbg_state;

    sd_cmd_ctrl #(.NCR_MAX(NCR), .PRE_BYTES(PRE)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_start      (cmd_start),
        .cmd_index      (cmd_index),
        .cmd_arg        (cmd_arg),
        .cmd_crc        (cmd_crc),
        .cmd_busy       (cmd_busy),
        .cmd_done       (cmd_done),
        .cmd_r1         (cmd_r1),
        .cmd_timeout    (cmd_timeout),
        .spi_wdata      (spi_wdata),
        .spi_write_en   (spi_write_en),
        .spi_read_en    (spi_read_en),
        .spi_rdata      (spi_rdata),
        .spi_write_busy (spi_write_busy),
        .spi_read_busy  (spi_read_busy),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic [7:0]  crc_byte;
        int          n_ff;
        logic [7:0]  resp;
        logic [7:0]  exp_r1;
        logic        exp_to;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int busy_len = 2;
    bit stall    = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] resp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // engine model: records bytes into the scoreboard and answers from resp_q
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk); #1;
            if (spi_write_en !== spi_read_en) chk("en_pair", {31'd0, spi_read_en}, {31'd0, spi_write_en});
            if (spi_write_en === 1'b1 && !rst) begin
                b = spi_wdata;
                xfer_cnt++;
                if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
                else                   chk("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                if (!stall) begin
                    spi_write_busy = 1'b1;
                    spi_read_busy  = 1'b1;
                end
                @(posedge clk); #1;
                if (!rst) begin
                    chk("en_one_cycle", {31'd0, spi_write_en}, 32'd0);
                    chk("wdata_stable", {24'd0, spi_wdata}, {24'd0, b});
                end
                if (!stall) begin
                    repeat (busy_len - 1) begin @(posedge clk); #1; end
                    spi_write_busy = 1'b0;
                    spi_read_busy  = 1'b0;
                    spi_rdata = (resp_q.size() != 0) ? resp_q.pop_front() : 8'hFF;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmd_done === 1'b1) begin
            done_cnt++;
            chk("busy_low_at_done", {31'd0, cmd_busy}, 32'd0);
        end
    end

    task automatic load_cmd(input vec_t v, output int nbytes);
        int npolls;
        exp_q.delete();
        resp_q.delete();
        npolls = (v.n_ff >= NCR) ? NCR : v.n_ff + 1;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'hFF);
        exp_q.push_back({2'b01, v.idx});
        exp_q.push_back(v.arg[31:24]);
        exp_q.push_back(v.arg[23:16]);
        exp_q.push_back(v.arg[15:8]);
        exp_q.push_back(v.arg[7:0]);
        exp_q.push_back(v.crc_byte);
        for (int i = 0; i < npolls; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < PRE + 6 + v.n_ff; i++) resp_q.push_back(8'hFF);
        resp_q.push_back(v.resp);
        nbytes = PRE + 6 + npolls;
    endtask

    task automatic start_cmd(input vec_t v);
        @(negedge clk);
        cmd_index = v.idx;
        cmd_arg   = v.arg;
        cmd_crc   = v.crc;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_index = 6'h3F;
        cmd_arg   = 32'hDEAD_BEEF;
        cmd_crc   = 7'h00;
        chk("busy_after_start", {31'd0, cmd_busy}, 32'd1);
        chk("first_enable", {30'd0, spi_write_en, spi_read_en}, 32'd3);
    endtask

    task automatic wait_done(output bit got);
        int c = 0;
        while (cmd_done !== 1'b1 && c < 800) begin
            @(negedge clk);
            c++;
        end
        got = (cmd_done === 1'b1);
        chk("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int nbytes, x0, d0;
        bit got;
        load_cmd(v, nbytes);
        x0 = xfer_cnt;
        d0 = done_cnt;
        start_cmd(v);
        wait_done(got);
        if (got) begin
            chk({tag, "_r1"}, {24'd0, cmd_r1}, {24'd0, v.exp_r1});
            chk({tag, "_timeout"}, {31'd0, cmd_timeout}, {31'd0, v.exp_to});
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, cmd_done}, 32'd0);
            chk({tag, "_r1_held"}, {24'd0, cmd_r1}, {24'd0, v.exp_r1});
            chk({tag, "_timeout_held"}, {31'd0, cmd_timeout}, {31'd0, v.exp_to});
        end
        chk({tag, "_nbytes"}, xfer_cnt - x0, nbytes);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int x0, d0, nbytes, c;
        bit got;

        vecs[0] = '{6'd0,  32'h0000_0000, 7'h4A, 8'h95, 2,   8'h01, 8'h01, 1'b0};
        vecs[1] = '{6'd8,  32'h0000_01AA, 7'h43, 8'h87, 0,   8'h01, 8'h01, 1'b0};
        vecs[2] = '{6'd0,  32'h0000_0000, 7'h4A, 8'h95, 255, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{6'd55, 32'h0000_0000, 7'h32, 8'h65, 1,   8'h00, 8'h00, 1'b0};
        vecs[4] = '{6'd41, 32'h4000_0000, 7'h3B, 8'h77, 3,   8'h05, 8'h05, 1'b0};
        vecs[5] = '{6'd0,  32'h0000_0000, 7'h4A, 8'h95, 7,   8'h7F, 8'h7F, 1'b0};

        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_index = 6'd0;
        cmd_arg = 32'd0;
        cmd_crc = 7'd0;
        spi_rdata = 8'hFF;
        spi_write_busy = 1'b0;
        spi_read_busy = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, cmd_busy}, 32'd0);
        chk("rst_done", {31'd0, cmd_done}, 32'd0);
        chk("rst_timeout", {31'd0, cmd_timeout}, 32'd0);
        chk("rst_r1", {24'd0, cmd_r1}, 32'hFF);
        chk("rst_wdata", {24'd0, spi_wdata}, 32'hFF);
        chk("rst_en", {30'd0, spi_write_en, spi_read_en}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

        for (int i = 0; i < 6; i++) begin
            busy_len = 2 + (i % 2);
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end
        busy_len = 2;

        // start pulses during busy and in the cmd_done cycle are ignored
        load_cmd(vecs[1], nbytes);
        x0 = xfer_cnt;
        d0 = done_cnt;
        start_cmd(vecs[1]);
        repeat (10) @(negedge clk);
        cmd_index = 6'd0;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done(got);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk("start_at_done_ignored", {31'd0, cmd_busy}, 32'd0);
        repeat (30) @(negedge clk);
        chk("ignore_nbytes", xfer_cnt - x0, nbytes);
        chk("ignore_done_count", done_cnt - d0, 1);
        chk("ignore_bytes_left", exp_q.size(), 0);
        chk("ignore_r1", {24'd0, cmd_r1}, 32'h01);

        // reset during SEND byte 3 aborts without cmd_done
        load_cmd(vecs[0], nbytes);
        x0 = xfer_cnt;
        d0 = done_cnt;
        start_cmd(vecs[0]);
        c = 0;
        while (xfer_cnt - x0 < PRE + 4 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("abort_reached_byte3", xfer_cnt - x0, PRE + 4);
        chk("abort_state_send", {29'd0, dbg_state}, {29'd0, ST_SEND});
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, cmd_busy}, 32'd0);
        chk("abort_done", {31'd0, cmd_done}, 32'd0);
        chk("abort_r1", {24'd0, cmd_r1}, 32'hFF);
        chk("abort_timeout", {31'd0, cmd_timeout}, 32'd0);
        chk("abort_wdata", {24'd0, spi_wdata}, 32'hFF);
        chk("abort_en", {30'd0, spi_write_en, spi_read_en}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.delete();
        chk("abort_no_done", done_cnt - d0, 0);
        run_cmd(vecs[0], "after_abort");

        // engine never raises busy: every byte completes through the guard as 0xFF
        stall = 1'b1;
        run_cmd('{6'd0, 32'h0000_0000, 7'h4A, 8'h95, 255, 8'h01, 8'hFF, 1'b1}, "stall");
        stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_ctrl.md
# sd_cmd_ctrl

SD-card SPI-mode command sequencer that sits directly above the SPI byte engine in the SD driver stack. It accepts one command request (index, argument, CRC), frames it into the 6-byte SPI command token, drives the byte engine one full-duplex byte at a time, then polls for the R1 response. It returns the R1 byte or a timeout flag to the card-init/data-transfer layer above.

## Interface

- NCR_MAX, 8: maximum number of response-poll bytes before timeout (1..255).
- PRE_BYTES, 1: number of 0xFF filler bytes sent before each command token (0..15).

Ports:
- clk  in  1  system clock, shared with the SPI byte engine.
- rst  in  1  reset, asynchronous, active-high.
- cmd_start  in  1  one-cycle request pulse; sampled only in IDLE.
- cmd_index  in  6  command index, sampled with cmd_start.
- cmd_arg  in  32  command argument, sampled with cmd_start.
- cmd_crc  in  7  CRC7 for the token; ignored when the CRC generator is compiled in.
- cmd_busy  out  1  high from the cycle after an accepted cmd_start until cmd_done.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_r1  out  8  R1 response; valid with cmd_done, held until the next accepted start.
- cmd_timeout  out  1  set with cmd_done when no response arrived; held like cmd_r1.
- spi_wdata  out  8  byte to the engine's data_write input.
- spi_write_en  out  1  one-cycle pulse to the engine.
- spi_read_en  out  1  one-cycle pulse; always asserted together with spi_write_en.
- spi_rdata  in  8  engine's data_read.
- spi_write_busy  in  1  engine write busy.
- spi_read_busy  in  1  engine read busy.

## Operation

- Every byte is a full-duplex transfer: spi_write_en and spi_read_en pulse together for exactly one cycle, with spi_wdata stable from the pulse until the transfer completes.
- Byte handshake sub-states:
  - ISSUE: pulse the enables.
  - ARM: wait for spi_write_busy|spi_read_busy = 1.
  - WAIT: wait for both busy = 0, then capture spi_rdata.
- Main FSM:
  - IDLE: accepts cmd_start, latches inputs, and moves to PRE, or to SEND when PRE_BYTES = 0.
  - PRE: sends PRE_BYTES × 0xFF.
  - SEND: sends bytes 0..5, in order:
    - {2'b01, cmd_index}
    - cmd_arg[31:24], [23:16], [15:8], [7:0]
    - {crc, 1'b1}
  - POLL: sends 0xFF and inspects the captured byte. If bit7 = 0, the byte is R1: go to DONE. Otherwise increment the poll counter; when the counter reaches NCR_MAX, go to DONE with timeout.
  - DONE: for one cycle, pulses cmd_done, drives cmd_r1 (0xFF on timeout) and cmd_timeout, then returns to IDLE.
- cmd_start while cmd_busy = 1 is ignored, with no queuing.
- Poll counter width is 8 bits and does not wrap; NCR_MAX = 255 gives 255 polls.
- Reset values: cmd_busy, cmd_done, cmd_timeout, spi_write_en and spi_read_en are 0; cmd_r1 = 8'hFF; spi_wdata = 8'hFF; FSM in IDLE.
- Reset asserted mid-command aborts immediately. No partial cmd_done is produced, and the engine is left to finish its byte on its own.

## Timing

- cmd_start at cycle N gives cmd_busy = 1 at N+1 and the first enable pulse at N+1.
- Per byte: 1 ISSUE cycle, then ARM (engine-dependent, ≥1 cycle), then WAIT. The next ISSUE follows in the cycle after both busy signals are sampled low.
- ARM has a 4-cycle guard. If busy never rises, the byte is treated as complete with spi_rdata = 0xFF, so a stalled engine cannot hang the FSM.
- Total bytes per command = PRE_BYTES + 6 + polls (1..NCR_MAX).
- cmd_busy falls in the same cycle as the cmd_done pulse.

## Configuration

- SD_CMD_CRC7_GEN_EN defined: CRC7 (polynomial x^7+x^3+1, init 0) is computed over token bytes 0..4 and inserted into byte 5; cmd_crc is ignored.
- Not defined: byte 5 = {cmd_crc, 1'b1} verbatim, and no CRC logic is synthesized.

## Structure

- Package sd_pkg holds:
  - FSM state enum and byte-handshake sub-state enum
  - SD_START_BITS = 2'b01, SD_STOP_BIT = 1'b1, SD_FILL_BYTE = 8'hFF
  - SD_CRC7_POLY = 7'h09
  - Handshake guard length 4
- Sub-module sd_crc7: byte-serial CRC7 update (clear, byte_valid, byte_in, crc_out), instantiated only under SD_CMD_CRC7_GEN_EN.

## Test plan

- CMD0, arg 0, CRC gen on, engine model answers 0xFF, 0xFF, 0x01 → bytes seen 0xFF, 0x40, 00, 00, 00, 00, 0x95; cmd_r1 = 0x01, cmd_timeout = 0, cmd_done once.
- CMD8, arg 0x000001AA, CRC gen on → token 0x48, 00, 00, 0x01, 0xAA, 0x87; response 0x01 on first poll → r1 = 0x01 after exactly 8 byte transfers.
- NCR_MAX = 8, engine always returns 0xFF → 8 polls, cmd_r1 = 0xFF, cmd_timeout = 1, cmd_busy low with cmd_done.
- Second cmd_start during busy, plus a start pulse in the same cycle as cmd_done → both ignored; exactly one token observed.
- rst asserted during SEND byte 3 → all outputs at reset values next cycle, no cmd_done; a new CMD0 afterwards completes normally.
- CRC gen off, cmd_crc = 7'h4A → byte 5 = 0x95; engine busy held low → guard expires and the sequence still completes with timeout.
